// File: rtl/slice_queue_arbiter_if.sv
// Handshake bundle between the slice queue arbiter, the slice generator, the tx queues
// and tx_control. The arbiter connects through the master modport; the surrounding
// logic (or a testbench) connects through the slave modport.
interface slice_queue_arbiter_if;
    logic [3:0] slice_en;
    logic [3:0] queue_req;
    logic       tx_done;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       tx_start;
    logic       timeout_err;
    logic       slice_overrun;

    modport master (
        input  slice_en,
        input  queue_req,
        input  tx_done,
        output grant_valid,
        output grant_idx,
        output tx_start,
        output timeout_err,
        output slice_overrun
    );

    modport slave (
        output slice_en,
        output queue_req,
        output tx_done,
        input  grant_valid,
        input  grant_idx,
        input  tx_start,
        input  timeout_err,
        input  slice_overrun
    );
endinterface

// File: rtl/slice_queue_arbiter.sv
// Grants the shared tx chain to one of four tx queues. Queues compete only while both
// requesting and inside their time slice. Selection is round-robin, one frame per grant,
// followed by an inter-frame holdoff. A watchdog releases a grant whose tx_done never
// arrives.
// Build option: define SLICE_ARB_Q0_PRIO_EN to give queue 0 strict priority; queues 1..3
// then round-robin among themselves and queue 0 grants leave the round-robin pointer alone.
module slice_queue_arbiter #(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    slice_queue_arbiter_if.master arb_bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_HOLDOFF = 2'd2;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic             r_grant_valid;
    logic [1:0]       r_grant_idx;
    logic [1:0]       r_last_idx;
    logic             r_tx_start;
    logic             r_timeout_err;
    logic             r_slice_overrun;
    logic [TO_W-1:0]  r_wd;
    logic [GAP_W-1:0] r_gap;
    logic [3:0]       r_slice_en_q;

    logic [3:0] w_eligible;
    logic [3:0] w_rr_elig;
    logic       w_q0_prio;
    logic       w_pick_valid;
    logic [1:0] w_pick_idx;
    logic       w_pick_upd;
    logic       w_owner_fall;

    assign w_eligible = arb_bus.queue_req & arb_bus.slice_en;

`ifdef SLICE_ARB_Q0_PRIO_EN
    // Queue 0 bypasses the rotation; the rotation itself never lands on queue 0.
    assign w_q0_prio = w_eligible[0];
    assign w_rr_elig = {w_eligible[3:1], 1'b0};
`else
    assign w_q0_prio = 1'b0;
    assign w_rr_elig = w_eligible;
`endif

    // Owner's slice enable seen high last cycle and low now.
    assign w_owner_fall = r_slice_en_q[r_grant_idx] & ~arb_bus.slice_en[r_grant_idx];

    // Pick the next owner: first eligible queue after the last round-robin winner.
    always_comb begin : pick
        logic [1:0] cand;
        cand         = '0;
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_pick_upd   = 1'b1;
        if (w_q0_prio) begin
            w_pick_valid = 1'b1;
            w_pick_idx   = 2'd0;
            w_pick_upd   = 1'b0;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                cand = r_last_idx + 2'(k);
                if (!w_pick_valid && w_rr_elig[cand]) begin
                    w_pick_valid = 1'b1;
                    w_pick_idx   = cand;
                end
            end
        end
    end

    // Track slice enables for owner falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slice_en_q <= '0;
        end else begin
            r_slice_en_q <= arb_bus.slice_en;
        end
    end

    // Grant FSM: IDLE arbitrates, BUSY waits for tx_done or watchdog, HOLDOFF spaces frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_grant_valid   <= 1'b0;
            r_grant_idx     <= 2'd0;
            r_last_idx      <= 2'd3;
            r_tx_start      <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_slice_overrun <= 1'b0;
            r_wd            <= '0;
            r_gap           <= '0;
        end else begin
            r_tx_start      <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_slice_overrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant_idx   <= w_pick_idx;
                        if (w_pick_upd) begin
                            r_last_idx <= w_pick_idx;
                        end
                        r_grant_valid <= 1'b1;
                        r_tx_start    <= 1'b1;
                        r_wd          <= '0;
                        r_state       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_slice_overrun <= w_owner_fall;
                    // tx_done takes precedence over a simultaneous watchdog expiry.
                    if (arb_bus.tx_done || (r_wd == TO_LAST)) begin
                        r_grant_valid <= 1'b0;
                        r_timeout_err <= ~arb_bus.tx_done;
                        r_gap         <= '0;
                        r_state       <= (GAP_CYCLES > 0) ? S_HOLDOFF : S_IDLE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign arb_bus.grant_valid   = r_grant_valid;
    assign arb_bus.grant_idx     = r_grant_idx;
    assign arb_bus.tx_start      = r_tx_start;
    assign arb_bus.timeout_err   = r_timeout_err;
    assign arb_bus.slice_overrun = r_slice_overrun;

endmodule

// File: doc/slice_queue_arbiter.md
# slice_queue_arbiter

Grants the shared tx chain to one of four tx queues, honouring the per-queue time-slice enables from the slice generator (slice_en0..3). Round-robin among queues that are both requesting and inside their slice, one frame per grant, with an inter-frame holdoff and a watchdog on the tx-done handshake. Sits in xpu between the slice generator and tx_control.

## Interface
- GAP_CYCLES, 4: idle clk cycles after each release before the next arbitration (0 allowed).
- TIMEOUT_CYCLES, 65535: max clk cycles a grant may wait for tx_done; must be in 1..2^TO_W-1.
- TO_W, 16: watchdog counter width.
- clk  in  1  block clock
- rst  in  1  asynchronous active-high reset
- slice_en  in  4  bit i = slice_en(i) from the slice generator
- queue_req  in  4  bit i = queue i has a frame ready (level)
- tx_done  in  1  one-cycle pulse: tx chain finished the granted frame
- grant_valid  out  1  a queue currently owns the tx chain
- grant_idx  out  2  owning queue (holds last value when grant_valid=0)
- tx_start  out  1  one-cycle pulse at grant
- timeout_err  out  1  one-cycle pulse when the watchdog releases a grant
- slice_overrun  out  1  one-cycle pulse when the owner's slice_en falls during its grant

## Operation
- eligible = queue_req & slice_en (combinational on inputs).
- States: IDLE, BUSY, HOLDOFF.
- IDLE: if eligible != 0, select first set bit searching last_idx+1, +2, +3, +4 (mod 4); register grant_idx and last_idx, assert grant_valid, pulse tx_start, clear watchdog, go BUSY. Else stay.
- BUSY: watchdog increments each cycle. tx_done=1 -> release. Else watchdog == TIMEOUT_CYCLES-1 -> release, pulse timeout_err. Release: grant_valid<=0, go HOLDOFF (GAP_CYCLES>0) or IDLE (GAP_CYCLES=0).
- HOLDOFF: count GAP_CYCLES cycles, then IDLE; requests ignored.
- Grant is never revoked by slice_en or queue_req falling; a falling edge of slice_en[grant_idx] in BUSY pulses slice_overrun (once per edge).
- tx_done outside BUSY is ignored.
- Widths: watchdog and gap counters saturate-free, reset on every entry; last_idx 2 bits wraps naturally.

## Timing
- Reset values: grant_valid=0, grant_idx=0, tx_start=0, timeout_err=0, slice_overrun=0, state IDLE, last_idx=3 (queue 0 wins first tie), counters 0.
- Arbitration latency: eligible sampled at edge N in IDLE -> grant_valid, grant_idx, tx_start visible after edge N (registered, 1 cycle).
- tx_start high exactly one cycle, coincident with first cycle of grant_valid.
- tx_done at edge M -> grant_valid=0 after edge M; next grant no earlier than edge M+GAP_CYCLES+1.
- tx_done and watchdog expiry on same edge: done wins, no timeout_err.
- Watchdog: with no tx_done, grant_valid is high for exactly TIMEOUT_CYCLES cycles; timeout_err coincides with first low cycle.
- tx_done on the tx_start cycle is accepted (1-cycle grant).
- rst asserted mid-grant: all outputs to reset values immediately (asynchronous), no timeout_err or tx_start emitted.

## Configuration
- SLICE_ARB_Q0_PRIO_EN defined: queue 0 is strict priority; if eligible[0] in IDLE, it is granted regardless of last_idx; queues 1..3 round-robin among themselves (search last_idx+1.. skipping 0), and last_idx is not updated by queue 0 grants.
- Not defined: plain 4-way round-robin as above.

## Test plan
- Reset, queue_req=4'b1111, slice_en=4'b1111, tx_done 3 cycles after each tx_start, GAP_CYCLES=4 -> grant_idx 0,1,2,3,0; successive tx_start pulses 8 cycles apart.
- queue_req=4'b0110, slice_en=4'b0010 -> only queue 1 granted; raise slice_en[2] -> after queue 1 release, queue 2 granted next.
- Grant queue 2, drop slice_en[2] mid-grant -> one slice_overrun pulse, grant_valid stays 1 until tx_done.
- TIMEOUT_CYCLES=10, never send tx_done -> grant_valid high 10 cycles, timeout_err pulses once, arbitration resumes after holdoff; tx_done on expiry cycle -> no timeout_err.
- Assert rst during BUSY -> grant_valid=0 immediately, next grant after rst release goes to queue 0; with SLICE_ARB_Q0_PRIO_EN and req=4'b1111 -> sequence 0,0,0 while queue 0 stays eligible.
